bus_arbiter: RTL

//  Round-robin arbiter and driver for the processor's shared 16-bit bus. Sources are register file, ALU result G, immediate DIN and memory.

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter_rr_picker.sv | 30 +++
 rtl/bus_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the processor bus arbiter: bus width, requester
// indices used by both the processor and the arbiter, and the FSM state type.
package bus_arbiter_pkg;

    localparam int BUS_WIDTH = 16;

    localparam int REQ_REG = 0;
    localparam int REQ_ALU = 1;
    localparam int REQ_DIN = 2;
    localparam int REQ_MEM = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first asserted request found
// when searching circularly upward from ptr.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int c;
            c = int'(ptr) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (req[c]) begin
                found = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and data mux for the shared processor bus, with a hold
// timeout that preempts a long-running owner and a halt input that parks the bus.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = BUS_WIDTH,
    parameter int MAX_HOLD = 8,
    parameter int IW       = $clog2(NREQ),
    parameter int HW       = $clog2(MAX_HOLD)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    input  logic                  halt,
    output logic [NREQ-1:0]       grant,
    output logic [IW-1:0]         owner,
    output logic [WIDTH-1:0]      bus,
    output logic                  bus_enable,
    output logic                  preempt,
    output arb_state_e            dbg_state
);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            preempt_q, preempt_d;

    logic [IW-1:0]   owner_next;
    logic [IW-1:0]   pick_ptr;
    logic [NREQ-1:0] pick_req;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            timeout;

    assign owner_next = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + IW'(1);
    assign timeout    = (hold_q == HW'(MAX_HOLD - 1));

    // While granted, search past the owner and ignore it so a timeout hands off to someone else.
    assign pick_ptr = (state_q == ST_GRANT) ? owner_next : rr_ptr_q;
    assign pick_req = (state_q == ST_GRANT) ? (req & ~grant_q) : req;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found && !halt) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    grant_d = NREQ'(1) << pick_idx;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (halt) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                end else if (!req[owner_q]) begin
                    rr_ptr_d = owner_next;
                    hold_d   = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                        grant_d = NREQ'(1) << pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (timeout && pick_found) begin
                    rr_ptr_d  = owner_next;
                    owner_d   = pick_idx;
                    grant_d   = NREQ'(1) << pick_idx;
                    hold_d    = '0;
                    preempt_d = 1'b1;
                end else if (!timeout) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant      = grant_q;
    assign owner      = owner_q;
    assign bus_enable = (state_q == ST_GRANT);
    assign bus        = bus_enable ? data_in[int'(owner_q)*WIDTH +: WIDTH] : '0;
    assign preempt    = preempt_q;
    assign dbg_state  = state_q;

endmodule
